// File: rtl/line_burst_ctrl.sv
// Cache-line burst controller: splits one line fill/writeback into 16-bit bus beats.
// Define LINE_BURST_CWF_EN to start read bursts at the requested word (critical word first).
module line_burst_ctrl #(
  parameter int data_words = 8,
  parameter int log_word   = 3,
  parameter int line_size  = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [15:0]          pmem_address,
  input  logic [line_size-1:0] pmem_wdata,
  output logic [line_size-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic [15:0]          bus_addr,
  output logic                 bus_read,
  output logic                 bus_write,
  output logic [15:0]          bus_wdata,
  input  logic [15:0]          bus_rdata,
  input  logic                 bus_ready,
  output logic [1:0]           dbg_state
);

  // Handshake: a beat is transferred on a rising edge where (bus_read|bus_write) && bus_ready.
  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, RESP} state_t;

  localparam logic [log_word:0] last_cnt = (log_word + 1)'(data_words - 1);

  state_t                state_q, state_d;
  logic [log_word-1:0]   beat_q, beat_d;
  logic [log_word:0]     cnt_q, cnt_d;
  logic [11:0]           base_q, base_d;
  logic [line_size-1:0]  wline_q, wline_d;
  logic [line_size-1:0]  rline_q, rline_d;
  logic [log_word-1:0]   start_word;
  logic [15:0]           beat_off;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^pmem_address[3:0];

`ifdef LINE_BURST_CWF_EN
  assign start_word = pmem_address[log_word:1];
`else
  assign start_word = '0;
`endif

  always_comb begin
    beat_off = '0;
    beat_off[log_word:1] = beat_q;
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    wline_d   = wline_q;
    rline_d   = rline_q;
    bus_addr  = '0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_wdata = '0;
    pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (pmem_write) begin
          base_d  = pmem_address[15:4];
          wline_d = pmem_wdata;
          beat_d  = '0;
          cnt_d   = '0;
          state_d = WR_BEAT;
        end else if (pmem_read) begin
          base_d  = pmem_address[15:4];
          beat_d  = start_word;
          cnt_d   = '0;
          state_d = RD_BEAT;
        end
      end
      RD_BEAT: begin
        bus_read = 1'b1;
        bus_addr = {base_q, 4'h0} + beat_off;
        if (bus_ready) begin
          rline_d[int'(beat_q)*16 +: 16] = bus_rdata;
          beat_d = beat_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == last_cnt) state_d = RESP;
        end
      end
      WR_BEAT: begin
        bus_write = 1'b1;
        bus_addr  = {base_q, 4'h0} + beat_off;
        bus_wdata = wline_q[int'(beat_q)*16 +: 16];
        if (bus_ready) begin
          beat_d = beat_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == last_cnt) state_d = RESP;
        end
      end
      RESP: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign pmem_rdata = rline_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_burst_ctrl.sv
// Scoreboard bench for line_burst_ctrl: stimulus pushes expected beats/responses, a monitor pops them.
// Covers the LINE_BURST_CWF_EN read order when that macro is defined.
module tb_line_burst_ctrl;
  localparam int DW  = 8;
  localparam int LS  = 128;
  localparam int BIG = 32'h7fff_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [15:0]   pmem_address = '0;
  logic [LS-1:0] pmem_wdata = '0;
  logic [LS-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [15:0]   bus_addr;
  logic          bus_read;
  logic          bus_write;
  logic [15:0]   bus_wdata;
  logic [15:0]   bus_rdata = '0;
  logic          bus_ready = 1'b1;
  logic [1:0]    dbg_state;

  line_burst_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .dbg_state(dbg_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int stall_lo = BIG;
  int stall_hi = BIG;

  // expected beat = {is_write, addr, wdata}
  logic [32:0]   exp_beat_q[$];
  int            exp_resp_cyc_q[$];
  logic [LS-1:0] exp_rdata_q[$];
  logic [LS-1:0] exp_line = '0;

  task automatic check(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // memory responder: word at address A holds 16'hA000 + A[3:1]
  always @(posedge clk) begin
    #2;
    bus_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    bus_rdata = 16'hA000 + 16'(bus_addr[3:1]);
  end

  // monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_read && bus_write) fail_now("both_strobes");
      if (bus_read || bus_write) begin
        if (exp_beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          check("beat_kind", LS'(bus_write), LS'(exp_beat_q[0][32]));
          check("beat_addr", LS'(bus_addr), LS'(exp_beat_q[0][31:16]));
          check("beat_wdata", LS'(bus_wdata), LS'(exp_beat_q[0][15:0]));
          if (bus_ready) void'(exp_beat_q.pop_front());
        end
      end else begin
        check("idle_wdata", LS'(bus_wdata), '0);
      end
      if (pmem_resp) begin
        if (exp_resp_cyc_q.size() == 0) fail_now("unexpected_resp");
        else begin
          check("resp_cycle", LS'(cyc), LS'(exp_resp_cyc_q.pop_front()));
          check("resp_rdata", pmem_rdata, exp_rdata_q.pop_front());
        end
      end
    end
  end

  task automatic wait_done();
    int guard = 0;
    while ((exp_beat_q.size() != 0 || exp_resp_cyc_q.size() != 0) && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    if (exp_beat_q.size() != 0 || exp_resp_cyc_q.size() != 0) begin
      fail_now("burst_timeout");
      exp_beat_q.delete();
      exp_resp_cyc_q.delete();
      exp_rdata_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("rdata_hold", pmem_rdata, exp_line);
  endtask

  task automatic run_burst(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [LS-1:0] wline, input int stall_beat, input int stall_n);
    int t0;
    int sw;
    logic [15:0] a;
    @(negedge clk);
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wline;
    @(posedge clk);
    #1;
    t0 = cyc;
    // mid-burst garbage on the request inputs must be ignored
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 16'hFFFE; pmem_wdata = ~wline;
    sw = 0;
`ifdef LINE_BURST_CWF_EN
    if (!wr) sw = int'(addr[3:1]);
`endif
    for (int k = 0; k < DW; k++) begin
      int w;
      w = (sw + k) % DW;
      a = {addr[15:4], 4'h0} + 16'(2 * w);
      if (wr) exp_beat_q.push_back({1'b1, a, wline[16*w +: 16]});
      else begin
        exp_beat_q.push_back({1'b0, a, 16'h0000});
        exp_line[16*w +: 16] = 16'hA000 + 16'(w);
      end
    end
    if (stall_n > 0) begin
      stall_lo = t0 + stall_beat;
      stall_hi = t0 + stall_beat + stall_n - 1;
    end
    exp_resp_cyc_q.push_back(t0 + 8 + stall_n);
    exp_rdata_q.push_back(exp_line);
    wait_done();
    stall_lo = BIG;
    stall_hi = BIG;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, pmem_rdata, '0);
    check({tag, "_resp"}, LS'(pmem_resp), '0);
    check({tag, "_addr"}, LS'(bus_addr), '0);
    check({tag, "_rd"}, LS'(bus_read), '0);
    check({tag, "_wr"}, LS'(bus_write), '0);
    check({tag, "_wdata"}, LS'(bus_wdata), '0);
    check({tag, "_state"}, LS'(dbg_state), '0);
  endtask

  task automatic abort_burst();
    int t0;
    logic [15:0] a;
    @(negedge clk);
    pmem_read = 1'b1; pmem_address = 16'h1230;
    @(posedge clk);
    #1;
    t0 = cyc;
    pmem_read = 1'b0;
    for (int w = 0; w < 4; w++) begin
      a = 16'h1230 + 16'(2 * w);
      exp_beat_q.push_back({1'b0, a, 16'h0000});
    end
    // beats 0..3 accept on edges 1..4; reset lands while beat 4 is presented
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_pending", LS'(exp_beat_q.size()), '0);
    check("abort_cycle", LS'(cyc), LS'(t0 + 4));
    exp_beat_q.delete();
    exp_line = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("abort_hold");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  logic [LS-1:0] wpat;
  logic [LS-1:0] wpat2;

  initial begin
    for (int i = 0; i < DW; i++) begin
      wpat[16*i +: 16]  = 16'(16'h1111 * (i + 1));
      wpat2[16*i +: 16] = 16'h5A00 + 16'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_burst(1'b1, 1'b0, 16'h1230, '0, 0, 0);
    run_burst(1'b0, 1'b1, 16'h0040, wpat, 0, 0);
    run_burst(1'b1, 1'b0, 16'h1230, '0, 3, 2);
`ifdef LINE_BURST_CWF_EN
    exp_line = '0;
    run_burst(1'b1, 1'b0, 16'h4000, '0, 0, 0);
    run_burst(1'b1, 1'b0, 16'h123A, '0, 0, 0);
`endif
    run_burst(1'b1, 1'b1, 16'h2000, wpat2, 0, 0);
    run_burst(1'b0, 1'b1, 16'h0080, wpat2, 0, 1);
    abort_burst();
    run_burst(1'b1, 1'b0, 16'h1230, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_burst_ctrl.md
LINE_BURST_CTRL -- requirements
Module: line_burst_ctrl

Interface
REQ-001 The block SHALL have parameter data_words, default 8, meaning the number of 16-bit words per cache line.
REQ-002 The block SHALL have parameter log_word, default 3, meaning log2(data_words).
REQ-003 The block SHALL have parameter line_size, default 128, meaning the line width in bits (16*data_words).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port pmem_read, input, 1, meaning the cache requests a line fill.
REQ-007 The block SHALL have port pmem_write, input, 1, meaning the cache requests a line writeback.
REQ-008 The block SHALL have port pmem_address, input, 16, meaning the byte address of the request; the line base is bits [15:4].
REQ-009 The block SHALL have port pmem_wdata, input, line_size, meaning the writeback line; word i is bits [16i+15:16i].
REQ-010 The block SHALL have port pmem_rdata, output, line_size, meaning the assembled fill line.
REQ-011 The block SHALL have port pmem_resp, output, 1, meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port bus_addr, output, 16, meaning the word address of the current beat.
REQ-013 The block SHALL have ports bus_read and bus_write, each output, 1, meaning the beat strobes.
REQ-014 The block SHALL have port bus_wdata, output, 16, meaning the write beat data.
REQ-015 The block SHALL have port bus_rdata, input, 16, meaning the read beat data.
REQ-016 The block SHALL have port bus_ready, input, 1, meaning the memory accepts or returns the current beat this cycle.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_BEAT, WR_BEAT and RESP.
REQ-018 In IDLE, pmem_write=1 SHALL latch the line base and pmem_wdata and move to WR_BEAT; pmem_write has priority when both requests are high.
REQ-019 In IDLE, pmem_read=1 with pmem_write=0 SHALL latch the line base and the start word and move to RD_BEAT.
REQ-020 In RD_BEAT/WR_BEAT the block SHALL hold bus_read/bus_write=1 and bus_addr={base,4'b0}+2*beat_word until bus_ready=1 on a clock edge.
REQ-021 On each accepted beat, a read SHALL store bus_rdata into word beat_word of pmem_rdata, a write SHALL have driven bus_wdata=latched word beat_word, and beat_word SHALL increment modulo data_words.
REQ-022 After data_words accepted beats the FSM SHALL move to RESP; RESP SHALL assert pmem_resp for exactly one cycle and then return to IDLE.
REQ-023 With bus_ready held at 1 and the request sampled at edge 0, beats SHALL occupy cycles 1-8 and pmem_resp SHALL be high in cycle 9.
REQ-024 Each bus_ready=0 cycle SHALL stall the beat and add one cycle of latency; bus strobes and bus_addr SHALL stay stable while stalled.
REQ-025 pmem_rdata SHALL change only on accepted read beats and SHALL hold its value through RESP until the next read beat.
REQ-026 Requests SHALL be sampled only in IDLE; pmem inputs that change mid-burst SHALL be ignored.
REQ-027 Outside RD_BEAT/WR_BEAT, bus_read, bus_write and bus_wdata SHALL be 0; pmem_resp SHALL be 0 outside RESP.
REQ-028 The cycle after RESP is IDLE, so a request still high then SHALL start a new burst; the cache must drop its request on pmem_resp.

Reset
REQ-029 While reset_n=0, the block SHALL be in IDLE with beat counter 0, pmem_rdata=0, pmem_resp=0, bus_addr=0, bus_read=0, bus_write=0 and bus_wdata=0, independent of clk.
REQ-030 Asserting reset_n mid-burst SHALL abort the burst with no pmem_resp; the first request after release SHALL start at beat count 0.

Configuration
REQ-031 With macro LINE_BURST_CWF_EN defined, read bursts SHALL start at word pmem_address[3:1] and wrap modulo data_words (critical word first).
REQ-032 Without LINE_BURST_CWF_EN, read bursts SHALL start at word 0; write bursts SHALL always start at word 0 in both builds.

Verification
REQ-033 The bench SHALL drive pmem_read, pmem_address=16'h1230 and bus_ready=1 with bus_rdata=16'hA000+word and SHALL check bus_addr 16'h1230..16'h123E, pmem_resp in cycle 9 and pmem_rdata word i = 16'hA000+i.
REQ-034 The bench SHALL drive pmem_write, pmem_address=16'h0040 and pmem_wdata words 16'h1111*(i+1) and SHALL check 8 bus_write beats carrying those words at 16'h0040..16'h004E and one pmem_resp.
REQ-035 The bench SHALL drive a read with bus_ready low for 2 cycles on beat 3 and SHALL check pmem_resp in cycle 11 and that bus_addr is stable during the stall.
REQ-036 With LINE_BURST_CWF_EN defined, the bench SHALL drive a read at pmem_address=16'h123A and SHALL check bus_addr order 123A,123C,123E,1230..1238 and a correctly placed pmem_rdata.
REQ-037 The bench SHALL drive pmem_read and pmem_write together and SHALL check that a write burst runs first; it SHALL also assert reset_n low at beat 4 and check no pmem_resp and all outputs 0.
